// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: qualifies the start edge, launches one
// datapath capture per character and holds the result on a valid/ready port.
module uart_rx_ctrl #(
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] baud_divisor,
  input  logic        start_detected,
  input  logic        rx_done,
  input  logic        parity_error,
  input  logic        stop_bit_error,
  input  logic [7:0]  dp_data,
  output logic        rx_start,
  output logic        rx_sel,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_parity_err,
  output logic        rx_frame_err,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        busy
);

  // Handshake: a byte moves on every rising clk where rx_valid && rx_ready;
  // rx_data/rx_parity_err/rx_frame_err hold steady while rx_valid waits.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    LAUNCH    = 3'd2,
    RECEIVE   = 3'd3,
    CHECK     = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] cnt;
  logic [10:0] cnt_next;
  logic [10:0] half;

  logic [7:0]  cap_data;
  logic        cap_perr;
  logic        cap_ferr;
  logic        capture;
  logic        accept;
  logic        load;
  logic        drop;

  assign rx_sel = enable;

  // Half a bit period, never zero so START_CHK always lasts at least a cycle.
  assign half = (baud_divisor[11:1] == 11'd0) ? 11'd1 : baud_divisor[11:1];

  assign accept  = rx_valid & rx_ready;
  assign capture = enable & (state == RECEIVE) & rx_done;
  assign load    = enable & (state == CHECK) & (~rx_valid | rx_ready);
  assign drop    = enable & (state == CHECK) & rx_valid & ~rx_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start_detected) begin
          cnt_next   = half;
          state_next = START_CHK;
        end
      end
      START_CHK: begin
        if (!start_detected) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 11'd1;
          if (cnt == 11'd1) begin
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_next = RECEIVE;
      end
      RECEIVE: begin
        if (rx_done) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = start_detected ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: begin
        if (!start_detected) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = 11'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 11'd0;
      rx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rx_start <= (state_next == LAUNCH);
      busy     <= (state_next != IDLE);
    end
  end

  // Datapath status is only guaranteed while rx_done is high, so snapshot it
  // there and let CHECK decide whether it reaches the holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_data <= 8'd0;
      cap_perr <= 1'b0;
      cap_ferr <= 1'b0;
    end else if (capture) begin
      cap_data <= dp_data;
      cap_perr <= parity_error;
      cap_ferr <= stop_bit_error;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= 8'd0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
    end else if (load) begin
      rx_data       <= cap_data;
      rx_parity_err <= cap_perr;
      rx_frame_err  <= cap_ferr;
      rx_valid      <= 1'b1;
    end else if (accept) begin
      rx_valid      <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun || (CLR_ON_READ && accept)) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a behavioural datapath drives frames, a
// monitor pops expected bytes from a scoreboard on every accepted transfer.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] baud_divisor;
  logic        start_detected;
  logic        rx_done;
  logic        parity_error;
  logic        stop_bit_error;
  logic [7:0]  dp_data;
  logic        rx_start;
  logic        rx_sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        overrun;
  logic        clr_overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int busy_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  uart_rx_ctrl #(.CLR_ON_READ(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .baud_divisor   (baud_divisor),
    .start_detected (start_detected),
    .rx_done        (rx_done),
    .parity_error   (parity_error),
    .stop_bit_error (stop_bit_error),
    .dp_data        (dp_data),
    .rx_start       (rx_start),
    .rx_sel         (rx_sel),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_parity_err  (rx_parity_err),
    .rx_frame_err   (rx_frame_err),
    .overrun        (overrun),
    .clr_overrun    (clr_overrun),
    .busy           (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // monitor: inputs change on negedge, so negedge+1 sees what the next posedge sees
  always begin
    @(negedge clk);
    #1;
    if (rx_start) start_cnt++;
    if (busy) busy_cnt++;
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h required none", {rx_parity_err, rx_frame_err, rx_data});
      end else begin
        mon_exp = exp_q.pop_front();
        check("accepted_byte", {22'd0, rx_parity_err, rx_frame_err, rx_data}, {22'd0, mon_exp});
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_latency(input logic [11:0] bd);
    int h;
    h = int'(bd[11:1]);
    if (h == 0) h = 1;
    return h + 1;
  endfunction

  // Drives the line low and waits for rx_start; returns on the LAUNCH cycle.
  task automatic start_frame();
    int lat;
    int b0;
    b0 = busy_cnt;
    start_detected = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rx_start && lat < 200);
    check("launch_latency", lat, exp_latency(baud_divisor));
    check("start_chk_cycles", busy_cnt - b0, exp_latency(baud_divisor) - 1);
  endtask

  // Full frame; returns on the CHECK cycle with rx_done already dropped.
  task automatic do_frame(input logic [7:0] d, input logic pe, input logic fe, input logic low_after);
    start_frame();
    start_detected = 1'b0;
    cyc(5);
    rx_done = 1'b1;
    dp_data = d;
    parity_error = pe;
    stop_bit_error = fe;
    start_detected = low_after;
    cyc(1);
    rx_done = 1'b0;
  endtask

  task automatic accept_one();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    cyc(1);
  endtask

  int s0;
  int b0;

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    baud_divisor = 12'd16;
    start_detected = 1'b0;
    rx_done = 1'b0;
    parity_error = 1'b0;
    stop_bit_error = 1'b0;
    dp_data = 8'h00;
    rx_ready = 1'b0;
    clr_overrun = 1'b0;
    cyc(3);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_err_bits", {rx_parity_err, rx_frame_err}, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_start", rx_start, 0);
    check("rx_sel_high", rx_sel, 1);
    reset = 1'b0;
    cyc(2);

    // 1: full frame 0xA5, line low 20 cycles
    s0 = start_cnt;
    start_frame();
    cyc(11);
    start_detected = 1'b0;
    cyc(30);
    check("a5_one_rx_start", start_cnt - s0, 1);
    check("a5_busy_receive", busy, 1);
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    rx_done = 1'b1;
    dp_data = 8'hA5;
    parity_error = 1'b0;
    stop_bit_error = 1'b0;
    cyc(1);
    rx_done = 1'b0;
    check("a5_valid_not_yet", rx_valid, 0);
    cyc(1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_err_bits", {rx_parity_err, rx_frame_err}, 0);
    check("a5_busy_idle", busy, 0);
    accept_one();
    check("a5_valid_cleared", rx_valid, 0);

    // 2: 3-cycle glitch
    s0 = start_cnt;
    b0 = busy_cnt;
    start_detected = 1'b1;
    cyc(3);
    start_detected = 1'b0;
    cyc(10);
    check("glitch_no_rx_start", start_cnt - s0, 0);
    check("glitch_busy_cycles", busy_cnt - b0, 3);
    check("glitch_idle", busy, 0);

    // 3: overrun with rx_ready low
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    do_frame(8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_no_flag_yet", overrun, 0);
    do_frame(8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1);
    check("ovr_flag", overrun, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_still_valid", rx_valid, 1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);

    // 4: accept in the CHECK cycle while holding 0x11
    exp_q.push_back({1'b0, 1'b0, 8'h33});
    do_frame(8'h33, 1'b0, 1'b0, 1'b0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("chk_accept_data", rx_data, 8'h33);
    check("chk_accept_valid", rx_valid, 1);
    check("chk_accept_no_ovr", overrun, 0);
    accept_one();

    // 5: stop-bit error, line stays low (break), minimum half period
    baud_divisor = 12'd1;
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    do_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    cyc(1);
    check("brk_frame_err", rx_frame_err, 1);
    check("brk_data", rx_data, 8'h5A);
    s0 = start_cnt;
    cyc(20);
    check("brk_wait_busy", busy, 1);
    check("brk_no_rx_start", start_cnt - s0, 0);
    start_detected = 1'b0;
    cyc(2);
    check("brk_idle", busy, 0);
    accept_one();

    // 6a: enable dropped in RECEIVE while holding a byte
    baud_divisor = 12'd3;
    exp_q.push_back({1'b1, 1'b0, 8'h44});
    do_frame(8'h44, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check("en_hold_valid", rx_valid, 1);
    start_frame();
    start_detected = 1'b0;
    cyc(3);
    enable = 1'b0;
    cyc(1);
    check("en_rx_sel_low", rx_sel, 0);
    check("en_idle", busy, 0);
    check("en_valid_kept", rx_valid, 1);
    enable = 1'b1;
    s0 = start_cnt;
    cyc(2);
    rx_done = 1'b1;
    dp_data = 8'h99;
    cyc(1);
    rx_done = 1'b0;
    cyc(5);
    check("en_data_kept", rx_data, 8'h44);
    check("en_perr_kept", rx_parity_err, 1);
    check("en_no_overrun", overrun, 0);
    check("en_no_rx_start", start_cnt - s0, 0);
    check("en_still_idle", busy, 0);
    accept_one();

    // 6b: reset in START_CHK while holding an unconsumed byte
    baud_divisor = 12'd16;
    do_frame(8'h55, 1'b0, 1'b0, 1'b0);
    cyc(1);
    check("rst_hold_valid", rx_valid, 1);
    start_detected = 1'b1;
    cyc(3);
    reset = 1'b1;
    start_detected = 1'b0;
    cyc(1);
    reset = 1'b0;
    check("rst_idle", busy, 0);
    check("rst_valid_cleared", rx_valid, 0);
    check("rst_data_cleared", rx_data, 0);
    check("rst_no_rx_start", rx_start, 0);
    s0 = start_cnt;
    cyc(15);
    check("rst_no_later_rx_start", start_cnt - s0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
